// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered glyphs and per-slot dead time.
// Optional per-digit blinking is compiled in when SEG_BLINK_EN is defined.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [NUM_DIGITS*5-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS*5-1:0] ALL_BLANK = {NUM_DIGITS{5'd18}};

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic                    pending;
    logic [NUM_DIGITS*5-1:0] shadow_codes;
    logic [NUM_DIGITS*5-1:0] active_codes;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic                    slot_end;
    logic                    frame_end;
    logic                    in_dead_time;
    logic [4:0]              cur_code;
    logic                    blink_off;

    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'd0:    decode = 7'b1000000;
            5'd1:    decode = 7'b1111001;
            5'd2:    decode = 7'b0100100;
            5'd3:    decode = 7'b0110000;
            5'd4:    decode = 7'b0011001;
            5'd5:    decode = 7'b0010010;
            5'd6:    decode = 7'b0000010;
            5'd7:    decode = 7'b1111000;
            5'd8:    decode = 7'b0000000;
            5'd9:    decode = 7'b0010000;
            5'd10:   decode = 7'b1001001;
            5'd11:   decode = 7'b0001000;
            5'd12:   decode = 7'b0000011;
            5'd13:   decode = 7'b1000110;
            5'd14:   decode = 7'b0100001;
            5'd15:   decode = 7'b0000110;
            5'd16:   decode = 7'b0001110;
            5'd17:   decode = 7'b1000010;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign slot_end     = (div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign frame_end    = slot_end && (scan_idx == IDX_W'(NUM_DIGITS - 1));
    assign in_dead_time = (div_cnt < DIV_W'(BLANK_CYCLES));
    assign cur_code     = active_codes[5*scan_idx +: 5];

`ifdef SEG_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_DIGITS-1:0] shadow_blink;
    logic [NUM_DIGITS-1:0] active_blink;
    logic [FC_W-1:0]       frame_cnt;
    logic                  blink_phase;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            shadow_blink <= '0;
            active_blink <= '0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else begin
            if (load)
                shadow_blink <= blink_mask;
            if (frame_end && pending)
                active_blink <= shadow_blink;
            if (frame_done) begin
                if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign blink_off = blink_phase && active_blink[scan_idx];
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            div_cnt      <= '0;
            scan_idx     <= '0;
            pending      <= 1'b0;
            shadow_codes <= ALL_BLANK;
            active_codes <= ALL_BLANK;
            shadow_dp    <= '0;
            active_dp    <= '0;
            an           <= '1;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end)
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            frame_done <= frame_end;

            if (load) begin
                shadow_codes <= digits_in;
                shadow_dp    <= dp_in;
            end

            // A load landing on the wrap cycle stays pending for the next frame.
            if (frame_end) begin
                if (pending) begin
                    active_codes <= shadow_codes;
                    active_dp    <= shadow_dp;
                end
                pending <= load;
            end else if (load) begin
                pending <= 1'b1;
            end

            if (in_dead_time) begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~(ONE_HOT0 << scan_idx);
                seg <= blink_off ? 7'h7F : decode(cur_code);
                dp  <= blink_off ? 1'b1 : ~active_dp[scan_idx];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed + randomized bench for seven_seg_scan_driver against a time-indexed display model.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic          clk_in = 1'b0;
    logic          reset = 1'b0;
    logic [19:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic          load = 1'b0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;
`ifdef SEG_BLINK_EN
    logic [3:0]    blink_mask = '0;
`endif

    seven_seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(2)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .load      (load),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [32];
    int  m_shadow [ND];
    int  m_active [ND];
    bit  m_sdp [ND];
    bit  m_adp [ND];
    bit  m_pend;
    int  c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, c);
        end
    endtask

    task automatic model_reset();
        c = 0;
        m_pend = 0;
        for (int i = 0; i < ND; i++) begin
            m_shadow[i] = 18;
            m_active[i] = 18;
            m_sdp[i]    = 0;
            m_adp[i]    = 0;
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            reset = 1'b1;
            load  = 1'b0;
            @(posedge clk_in);
            #1;
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dp", 32'(dp), 32'h1);
            chk("rst_fd", 32'(frame_done), 32'h0);
        end
        model_reset();
    endtask

    // Model position c = number of clocked cycles since reset released.
    task automatic step(input bit ld, input logic [19:0] d, input logic [3:0] p);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        int         pos;
        int         idx;
        bit         wrap;
        @(negedge clk_in);
        reset     = 1'b0;
        load      = ld;
        digits_in = d;
        dp_in     = p;
        pos  = c % RD;
        idx  = (c / RD) % ND;
        wrap = ((c % FRAME) == FRAME - 1);
        e_an = 4'hF;
        if (pos < BC) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_an[idx] = 1'b0;
            e_seg     = seg_tab[m_active[idx]];
            e_dp      = !m_adp[idx];
        end
        e_fd = wrap;
        if (wrap && m_pend) begin
            for (int i = 0; i < ND; i++) begin
                m_active[i] = m_shadow[i];
                m_adp[i]    = m_sdp[i];
            end
        end
        if (ld) begin
            for (int i = 0; i < ND; i++) begin
                m_shadow[i] = int'(d[5*i +: 5]);
                m_sdp[i]    = p[i];
            end
        end
        m_pend = wrap ? ld : (m_pend | ld);
        c++;
        @(posedge clk_in);
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("one_anode", 32'($countones(~an) <= 1), 32'h1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 20'h0, 4'h0);
    endtask

    task automatic idle_until(input int frame_pos);
        for (int k = 0; k < FRAME && (c % FRAME) != frame_pos; k++) step(1'b0, 20'h0, 4'h0);
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b1001001; seg_tab[11] = 7'b0001000;
        seg_tab[12] = 7'b0000011; seg_tab[13] = 7'b1000110; seg_tab[14] = 7'b0100001;
        seg_tab[15] = 7'b0000110; seg_tab[16] = 7'b0001110; seg_tab[17] = 7'b1000010;
        for (int i = 18; i < 32; i++) seg_tab[i] = 7'b1111111;
        model_reset();

        // Reset and idle scan of blank glyphs
        do_reset(3);
        idle(2 * FRAME);

        // Basic load: d3=11 d2=2 d1=0 d0=9, dp on digit 1
        step(1'b1, {5'd11, 5'd2, 5'd0, 5'd9}, 4'b0010);
        idle(2 * FRAME);

        // Two loads in one frame: last wins
        idle_until(10);
        step(1'b1, {5'd1, 5'd3, 5'd5, 5'd7}, 4'b1000);
        idle_until(20);
        step(1'b1, {5'd12, 5'd13, 5'd14, 5'd15}, 4'b0101);
        idle(FRAME + 4);

        // Load on the wrap cycle lands one frame later
        idle_until(FRAME - 1);
        step(1'b1, {5'd16, 5'd17, 5'd4, 5'd6}, 4'b1111);
        idle(2 * FRAME);

        // Blank and out-of-range codes
        step(1'b1, {5'd18, 5'd31, 5'd25, 5'd10}, 4'b0000);
        idle(2 * FRAME);

        // Reset mid-slot with a pending load outstanding
        step(1'b1, {5'd8, 5'd8, 5'd8, 5'd8}, 4'b1111);
        idle_until(21);
        do_reset(1);
        idle(2 * FRAME);

        // Randomized loads
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) == 0), 20'($urandom), 4'($urandom));
        end
        idle(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display. Holds a double-buffered set of 5-bit glyph codes and scans one digit per refresh slot. Each slot has a dead-time gap with all anodes off to suppress ghosting. It sits between the display-content logic and the board pins, and extends the single-digit glyph decode with scanning, frame-synchronous update and decimal points.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
REFRESH_DIV, 100000, clk_in cycles per digit slot; must be >= 2.
BLANK_CYCLES, 1000, dead-time cycles at the start of each slot; must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV.
BLINK_FRAMES, 250, frames per blink half-period; used only with SEG_BLINK_EN.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous reset, active-high.
digits_in  input  NUM_DIGITS*5  glyph codes; digit i is bits [5i+4:5i].
dp_in  input  NUM_DIGITS  decimal point request, 1 = lit; bit i belongs to digit i.
load  input  1  1-cycle strobe that captures digits_in/dp_in into the shadow buffer.
an  output  NUM_DIGITS  anodes, active-low; bit i drives digit i.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.
frame_done  output  1  1-cycle pulse at every frame wrap.
blink_mask  input  NUM_DIGITS  per-digit blink enable (present only with SEG_BLINK_EN).

Behaviour:
- Clock and reset: single clock clk_in; reset is synchronous, active-high.
- Reset values:
  - div_cnt=0, scan_idx=0, pending=0.
  - Shadow and active codes all 18 (blank); dp buffers 0.
  - Outputs: an=all 1, seg=7'h7F, dp=1, frame_done=0.
- Slot counter: div_cnt counts 0..REFRESH_DIV-1 and wraps.
- Digit advance: on wrap, scan_idx increments, going from NUM_DIGITS-1 back to 0.
- Frame wrap (the cycle div_cnt==REFRESH_DIV-1 and scan_idx==NUM_DIGITS-1):
  - frame_done is registered high for the following cycle.
  - If pending=1, active<=shadow (codes and dp).
  - pending<=load.
- Load: shadow<=inputs and pending<=1 on any cycle with load=1.
  - A load on the wrap cycle writes the shadow, but the wrap copies the pre-load shadow; the new data appears after the next wrap.
  - Repeated loads within a frame: the last one wins.
- Output register: all outputs are registered from the current div_cnt/scan_idx/active state, giving 1-cycle latency.
  - div_cnt < BLANK_CYCLES: an=all 1, seg=7'h7F, dp=1.
  - Otherwise: an = ~(1<<scan_idx), seg = decode(active[scan_idx]), dp = ~active_dp[scan_idx].
- Decode table (active-low):
  - Digits: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - Symbols and letters: 10(||):1001001, 11(A):0001000, 12(b):0000011, 13(C):1000110, 14(d):0100001, 15(E):0000110, 16(F):0001110, 17(G):1000010.
  - 18 and all codes 19..31: 1111111. No code leaves seg undriven or holds the previous value.
- At most one anode is low in any cycle; no anode is low during dead time.
- Reset mid-slot: on the next edge all state and outputs return to reset values; the scan restarts at digit 0.

Optional Feature:
SEG_BLINK_EN:
- Defined:
  - blink_mask is captured with load into the shadow and transferred to active at frame wrap, like the codes.
  - frame_cnt counts frame_done pulses 0..BLINK_FRAMES-1; on its wrap, blink_phase toggles. Both reset to 0.
  - While blink_phase=1 and active_blink[scan_idx]=1: seg=7'h7F and dp=1, but the anode is still driven, so slot timing is unchanged.
- Undefined: no blink_mask port, no frame_cnt, no blink logic; behaviour is exactly as above.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
1. Reset held 3 cycles, then released with no load -> an=4'b1111, seg=7'h7F, dp=1 during reset; after release, anodes cycle 1110,1101,1011,0111 with seg=7'h7F throughout; frame_done pulses every 32 cycles.
2. load with codes d3=11, d2=2, d1=0, d0=9 and dp_in=4'b0010 -> after the next frame_done, digit0 slot shows an=1110, seg=0010000 for 6 cycles after 2 dead cycles; digit1 shows seg=1000000, dp=0; digit3 shows seg=0001000.
3. load mid-frame, then a second load with different data before the wrap -> display unchanged until frame_done, then shows the second data; load on the wrap cycle itself -> applied one frame later.
4. Codes 10, 25, 31, 18 -> seg=1001001, 1111111, 1111111, 1111111; never more than one anode low; all anodes high when div_cnt<2.
5. reset pulsed while scan_idx=2, div_cnt=5 -> the next cycle shows all-off outputs, active codes blank, pending cleared; the next slot starts at digit 0.
6. (SEG_BLINK_EN) blink_mask=4'b0001 loaded -> digit0 segments alternate lit for 2 frames / blank for 2 frames while an=1110 still asserts; other digits are steady.
